// File: rtl/nn_arb_pkg.sv
// Shared definitions for the nn_core_arbiter slice.
//   - default core stream widths (IN_W_DEF / OUT_W_DEF)
//   - arbiter state encoding (ST_RUN / ST_DRAIN)
//   - rr_pick(): round-robin grant search over up to 8 requesters
package nn_arb_pkg;

   localparam int IN_W_DEF  = 180;  // 10 features x 18 bit
   localparam int OUT_W_DEF = 18;
   localparam int RR_MAX    = 8;    // widest requester vector rr_pick handles

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Returns the first index with vld set, searching ptr, ptr+1, ... .
   // Callers zero-pad vld above N_REQ; the zero bits are skipped, so a
   // modulo-8 walk visits live requesters in the same order as a modulo-N_REQ
   // walk. With no valid bit the result is ptr (callers gate on |vld).
   function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] vld,
                                          input logic [2:0]        ptr);
      logic [2:0] idx;
      logic [2:0] pick;
      logic       hit;
      pick = ptr;
      hit  = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         idx = ptr + 3'(k);
         if (!hit && vld[idx]) begin
            pick = idx;
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/nn_arb_tag_fifo.sv
// In-order tag FIFO: holds the requester index of every transaction the core
// has accepted but not yet returned. Registered output, no fall-through.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write a tag (ignored when full)
//   pop           drop the head tag (ignored when empty)
//   dout          head tag, valid while !empty
//   full, empty   occupancy flags
//   count         exact occupancy 0..DEPTH
module nn_arb_tag_fifo
   import nn_arb_pkg::*;
#(
   parameter int DEPTH = 4,  // power of 2, >= 2
   parameter int TAG_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [TAG_W-1:0]         din,
   output logic [TAG_W-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [TAG_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // NOTE: storage has no reset; entries are only read once count says they
   // were written, so clearing them would just add reset fan-out.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;  // power-of-2 depth wraps for free
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;          // idle, or push and pop together
         endcase
      end
   end

endmodule

// File: rtl/nn_core_arbiter.sv
// Shares one HLS inference core among N_REQ requesters. Requests are granted
// round-robin and passed straight through to the core; the requester index of
// each accepted request is queued in order so every core result is routed back
// to the right requester. drain_req quiesces the core: no new accepts, while
// in-flight results keep returning.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_dat/vld/rdy          requester input streams (slice i = [i*IN_W +: IN_W])
//   rsp_dat/vld/rdy          result stream, data broadcast, rsp_vld one-hot
//   core_in_dat/vld/rdy      to the core input_1_rsc_* interface
//   core_out_dat/vld/rdy     from the core layer5_out_rsc_* interface
//   drain_req                level; blocks accepts until released and empty
//   idle, inflight           nothing in flight / exact in-flight count
//   err                      sticky: core produced a result with nothing in flight
// Build option NN_CORE_ARBITER_PERF_EN adds saturating 32-bit counters
// perf_acc_cnt (accepts) and perf_cmp_cnt (completions).
module nn_core_arbiter
   import nn_arb_pkg::*;
#(
   parameter int N_REQ = 4,      // 2..8
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int DEPTH = 4,      // power of 2
   parameter int TAG_W = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ*IN_W-1:0]    req_dat,
   input  logic [N_REQ-1:0]         req_vld,
   output logic [N_REQ-1:0]         req_rdy,
   output logic [OUT_W-1:0]         rsp_dat,
   output logic [N_REQ-1:0]         rsp_vld,
   input  logic [N_REQ-1:0]         rsp_rdy,
   output logic [IN_W-1:0]          core_in_dat,
   output logic                     core_in_vld,
   input  logic                     core_in_rdy,
   input  logic [OUT_W-1:0]         core_out_dat,
   input  logic                     core_out_vld,
   output logic                     core_out_rdy,
   input  logic                     drain_req,
   output logic                     idle,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic                     err
`ifdef NN_CORE_ARBITER_PERF_EN
  ,output logic [31:0]              perf_acc_cnt,
   output logic [31:0]              perf_cmp_cnt
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] grant;
   logic [TAG_W-1:0] head;
   logic             any_vld;
   logic             can_acc;
   logic             acc;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;

   // ---------------- input side: round-robin grant ----------------
   assign any_vld = |req_vld;
   assign grant   = TAG_W'(rr_pick(RR_MAX'(req_vld), 3'(rr_ptr)));

   // drain_req is folded in directly so a request pending in the cycle drain
   // rises is refused. The full check ignores a same-cycle pop on purpose:
   // using it would chain rsp_rdy combinationally into req_rdy.
   assign can_acc     = ~rst & (state == ST_RUN) & ~drain_req & ~fifo_full;
   assign core_in_vld = can_acc & any_vld;
   assign core_in_dat = (any_vld && !rst) ? req_dat[grant*IN_W +: IN_W] : '0;
   assign req_rdy     = (core_in_vld && core_in_rdy) ? (N_REQ'(1) << grant) : '0;
   assign acc         = core_in_vld & core_in_rdy;

   // ---------------- return side: route to FIFO head ----------------
   assign rsp_dat      = core_out_dat;
   assign rsp_vld      = (core_out_vld && !fifo_empty) ? (N_REQ'(1) << head) : '0;
   assign core_out_rdy = ~fifo_empty & rsp_rdy[head];
   assign pop          = core_out_vld & core_out_rdy;
   assign idle         = fifo_empty;

   nn_arb_tag_fifo #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (acc),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (inflight)
   );

   // ---------------- RUN / DRAIN control ----------------
   // NOTE: every signal written here gets its default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN:   if (drain_req)                 state_nxt = ST_DRAIN;
         ST_DRAIN: if (!drain_req && fifo_empty)  state_nxt = ST_RUN;
         default:                                 state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_RUN;
         rr_ptr <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         // Pointer moves past the winner only on an accept, so an unaccepted
         // grant keeps its priority.
         if (acc) rr_ptr <= (grant == TAG_W'(N_REQ-1)) ? '0 : grant + 1'b1;
         if (core_out_vld && fifo_empty) err <= 1'b1;
      end
   end

`ifdef NN_CORE_ARBITER_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_acc_cnt <= '0;
         perf_cmp_cnt <= '0;
      end else begin
         if (acc && (perf_acc_cnt != '1)) perf_acc_cnt <= perf_acc_cnt + 1'b1;
         if (pop && (perf_cmp_cnt != '1)) perf_cmp_cnt <= perf_cmp_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nn_core_arbiter.sv
// Directed bench for nn_core_arbiter with a 3-cycle in-order core stub and a
// scoreboard of expected {requester, result} pairs checked on every cycle.
module tb_nn_core_arbiter;

   localparam int N     = 4;
   localparam int IN_W  = 180;
   localparam int OUT_W = 18;
   localparam int DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [IN_W-1:0]       slc [N];
   logic [N*IN_W-1:0]     req_dat;
   logic [N-1:0]          req_vld;
   logic [N-1:0]          req_rdy;
   logic [OUT_W-1:0]      rsp_dat;
   logic [N-1:0]          rsp_vld;
   logic [N-1:0]          rsp_rdy;
   logic [IN_W-1:0]       core_in_dat;
   logic                  core_in_vld;
   logic                  core_in_rdy;
   logic [OUT_W-1:0]      core_out_dat;
   logic                  core_out_vld;
   logic                  core_out_rdy;
   logic                  drain_req;
   logic                  idle;
   logic [2:0]            inflight;
   logic                  err;
`ifdef NN_CORE_ARBITER_PERF_EN
   logic [31:0]           perf_acc_cnt;
   logic [31:0]           perf_cmp_cnt;
`endif

   // core stub controls
   logic                  out_en;
   logic                  err_inj;
   logic                  stub_vld;
   logic [OUT_W-1:0]      stub_dat;

   int n_vec  = 0;
   int n_miss = 0;

   assign req_dat      = {slc[3], slc[2], slc[1], slc[0]};
   assign core_out_vld = err_inj | (out_en & stub_vld);
   assign core_out_dat = stub_dat;

   always #5 clk = ~clk;

   nn_core_arbiter #(
      .N_REQ (N), .IN_W (IN_W), .OUT_W (OUT_W), .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_dat      (req_dat),
      .req_vld      (req_vld),
      .req_rdy      (req_rdy),
      .rsp_dat      (rsp_dat),
      .rsp_vld      (rsp_vld),
      .rsp_rdy      (rsp_rdy),
      .core_in_dat  (core_in_dat),
      .core_in_vld  (core_in_vld),
      .core_in_rdy  (core_in_rdy),
      .core_out_dat (core_out_dat),
      .core_out_vld (core_out_vld),
      .core_out_rdy (core_out_rdy),
      .drain_req    (drain_req),
      .idle         (idle),
      .inflight     (inflight),
      .err          (err)
`ifdef NN_CORE_ARBITER_PERF_EN
     ,.perf_acc_cnt (perf_acc_cnt),
      .perf_cmp_cnt (perf_cmp_cnt)
`endif
   );

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // What the stub core computes from an input word.
   function automatic logic [OUT_W-1:0] res(input logic [IN_W-1:0] d);
      return d[17:0] + d[179:162];
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return p;
   endfunction

   function automatic int idx1h(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[k]) return k;
      return -1;
   endfunction

   // ---------------- core stub: in order, 3-cycle latency ----------------
   typedef struct {
      logic [OUT_W-1:0] d;
      int               due;
   } core_t;
   core_t cq[$];
   int    cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         cq.delete();
         stub_vld <= 1'b0;
         stub_dat <= '0;
      end else begin
         if (core_out_vld && core_out_rdy && stub_vld && cq.size() > 0) void'(cq.pop_front());
         if (core_in_vld && core_in_rdy) cq.push_back('{d: res(core_in_dat), due: cyc + 3});
         if (cq.size() > 0 && cq[0].due <= cyc) begin
            stub_vld <= 1'b1;
            stub_dat <= cq[0].d;
         end else begin
            stub_vld <= 1'b0;
            stub_dat <= '0;
         end
      end
   end

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      int               tag;
      logic [OUT_W-1:0] dat;
   } sb_t;
   sb_t sb[$];
   int  mptr   = 0;
   bit  mdrain = 0;
   bit  merr   = 0;
   int  n_acc  = 0;
   int  done   [N];
   int  dut_gl[$];
   int  rsp_ord[$];

   int         sz, g, ht;
   bit         can, nxt_drain;
   logic       exp_vld;
   logic [N-1:0] exp_rdy, exp_rsp;
   logic [IN_W-1:0] exp_dat;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         mptr   = 0;
         mdrain = 0;
         merr   = 0;
      end else begin
         sz = sb.size();
         chk("inflight", 192'(inflight), 192'(sz));
         chk("idle",     192'(idle),     192'(sz == 0));
         chk("err",      192'(err),      192'(merr));

         // input side
         can     = !mdrain && !drain_req && (sz < DEPTH);
         g       = pick(req_vld, mptr);
         exp_vld = can && (req_vld != '0);
         exp_rdy = (exp_vld && core_in_rdy) ? (N'(1) << g) : '0;
         exp_dat = (req_vld != '0) ? slc[g] : '0;
         chk("core_in_vld", 192'(core_in_vld), 192'(exp_vld));
         chk("req_rdy",     192'(req_rdy),     192'(exp_rdy));
         chk("core_in_dat", 192'(core_in_dat), 192'(exp_dat));

         // return side
         ht      = (sz > 0) ? sb[0].tag : 0;
         exp_rsp = (core_out_vld && sz > 0) ? (N'(1) << ht) : '0;
         chk("rsp_vld",      192'(rsp_vld),      192'(exp_rsp));
         chk("core_out_rdy", 192'(core_out_rdy), 192'((sz > 0) && rsp_rdy[ht]));
         if (exp_rsp != '0) chk("rsp_dat", 192'(rsp_dat), 192'(sb[0].dat));

         // trace what the DUT actually did, for order checks
         if (req_rdy != '0) dut_gl.push_back(idx1h(req_rdy));
         if ((rsp_vld & rsp_rdy) != '0) begin
            rsp_ord.push_back(idx1h(rsp_vld));
            done[idx1h(rsp_vld)]++;
         end

         // advance model to the state after the coming edge
         nxt_drain = mdrain ? !(!drain_req && sz == 0) : drain_req;
         if (core_out_vld && sz == 0) merr = 1;
         if (core_out_vld && sz > 0 && rsp_rdy[ht]) void'(sb.pop_front());
         if (exp_vld && core_in_rdy) begin
            sb.push_back('{tag: g, dat: res(slc[g])});
            mptr = (g + 1) % N;
            n_acc++;
         end
         mdrain = nxt_drain;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int base;

   initial begin
      rst         = 1'b1;
      req_vld     = '0;
      rsp_rdy     = '1;
      core_in_rdy = 1'b1;
      drain_req   = 1'b0;
      out_en      = 1'b1;
      err_inj     = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 6; j++) slc[i][j*30 +: 30] = 30'($urandom);

      // reset values, with requesters already valid
      req_vld = '1;
      #12;
      chk("rst_idle",         192'(idle),         192'(1));
      chk("rst_inflight",     192'(inflight),     192'(0));
      chk("rst_req_rdy",      192'(req_rdy),      192'(0));
      chk("rst_core_in_vld",  192'(core_in_vld),  192'(0));
      chk("rst_core_in_dat",  192'(core_in_dat),  192'(0));
      chk("rst_rsp_vld",      192'(rsp_vld),      192'(0));
      chk("rst_core_out_rdy", 192'(core_out_rdy), 192'(0));
      chk("rst_err",          192'(err),          192'(0));
      req_vld = '0;
      @(posedge clk); #1 rst = 1'b0;

      // 1: single requester, known vector -> 18'h0000F
      slc[0] = 180'hF;
      @(posedge clk); #1 req_vld = 4'b0001;
      @(posedge clk); #1 req_vld = 4'b0000;
      @(negedge clk);
      chk("t1_inflight_1", 192'(inflight), 192'(1));
      for (int i = 0; i < 20 && rsp_vld == '0; i++) @(negedge clk);
      chk("t1_rsp_vld", 192'(rsp_vld), 192'(4'b0001));
      chk("t1_rsp_dat", 192'(rsp_dat), 192'(18'h0000F));
      @(negedge clk);
      chk("t1_inflight_0", 192'(inflight), 192'(0));
      chk("t1_idle",       192'(idle),     192'(1));

      // 2: fairness, 100 transactions from a fresh round-robin pointer
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         done[i] = 0;
         for (int j = 0; j < 6; j++) slc[i][j*30 +: 30] = 30'($urandom);
      end
      dut_gl.delete();
      rsp_ord.delete();
      base    = n_acc;
      req_vld = 4'b1111;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (n_acc - base >= 100) break;
      end
      req_vld = '0;
      for (int i = 0; i < 50 && !idle; i++) @(negedge clk);
      chk("t2_accepts", 192'(n_acc - base),   192'(100));
      chk("t2_ngrant",  192'(dut_gl.size()),  192'(100));
      chk("t2_nrsp",    192'(rsp_ord.size()), 192'(100));
      for (int k = 0; k < 100 && k < dut_gl.size(); k++)
         chk($sformatf("t2_grant_%0d", k), 192'(dut_gl[k]), 192'(k % N));
      for (int k = 0; k < 100 && k < rsp_ord.size(); k++)
         chk($sformatf("t2_rsp_%0d", k), 192'(rsp_ord[k]), 192'(k % N));
      for (int i = 0; i < N; i++)
         chk($sformatf("t2_done_%0d", i), 192'(done[i]), 192'(25));

      // 3: full FIFO, then one pop -> accept only on the following cycle
      base    = n_acc;
      out_en  = 1'b0;
      req_vld = 4'b1111;
      repeat (8) @(posedge clk);
      #1;
      chk("t3_accepts", 192'(n_acc - base), 192'(4));
      @(negedge clk);
      chk("t3_inflight_full", 192'(inflight),    192'(4));
      chk("t3_req_rdy_full",  192'(req_rdy),     192'(0));
      chk("t3_in_vld_full",   192'(core_in_vld), 192'(0));
      @(posedge clk); #1 out_en = 1'b1;
      @(negedge clk);
      chk("t3_pop_rdy",         192'(core_out_rdy), 192'(1));
      chk("t3_no_acc_same_cyc", 192'(req_rdy),      192'(0));
      @(posedge clk); #1 out_en = 1'b0;
      @(negedge clk);
      chk("t3_acc_next_cyc", 192'(core_in_vld), 192'(1));
      chk("t3_inflight_3",   192'(inflight),    192'(3));
      @(negedge clk);
      chk("t3_inflight_refill", 192'(inflight), 192'(4));
      @(posedge clk); #1;
      req_vld = '0;
      out_en  = 1'b1;
      for (int i = 0; i < 50 && !idle; i++) @(negedge clk);
      chk("t3_drained", 192'(idle), 192'(1));

      // 4: back-pressure with head tag 2
      rsp_rdy = 4'b1011;
      @(posedge clk); #1 req_vld = 4'b0100;
      @(posedge clk); #1 req_vld = 4'b0000;
      for (int i = 0; i < 20 && !core_out_vld; i++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4_hold_rdy_%0d", k), 192'(core_out_rdy), 192'(0));
         chk($sformatf("t4_hold_vld_%0d", k), 192'(rsp_vld),      192'(4'b0100));
         @(negedge clk);
      end
      @(posedge clk); #1 rsp_rdy = 4'b1111;
      @(negedge clk);
      chk("t4_release_rdy", 192'(core_out_rdy), 192'(1));
      chk("t4_release_vld", 192'(rsp_vld),      192'(4'b0100));
      @(negedge clk);
      chk("t4_idle", 192'(idle), 192'(1));

      // 5: drain with 3 in flight; drain rises while a grant is pending
      base    = n_acc;
      out_en  = 1'b0;
      @(posedge clk); #1 req_vld = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (n_acc - base >= 3) break;
      end
      drain_req = 1'b1;
      @(negedge clk);
      chk("t5_no_acc_vld", 192'(core_in_vld), 192'(0));
      chk("t5_no_acc_rdy", 192'(req_rdy),     192'(0));
      repeat (4) @(posedge clk);
      #1;
      chk("t5_accepts", 192'(n_acc - base), 192'(3));
      @(negedge clk);
      chk("t5_inflight", 192'(inflight), 192'(3));
      out_en = 1'b1;
      for (int i = 0; i < 50 && !idle; i++) @(negedge clk);
      chk("t5_idle", 192'(idle), 192'(1));
      @(posedge clk); #1 drain_req = 1'b0;
      @(negedge clk);
      chk("t5_still_drain", 192'(core_in_vld), 192'(0));
      @(negedge clk);
      chk("t5_resume", 192'(core_in_vld), 192'(1));
      @(posedge clk); #1 req_vld = '0;
      for (int i = 0; i < 50 && !idle; i++) @(negedge clk);
      chk("t5_drained", 192'(idle), 192'(1));

      // 6: result with empty FIFO sets sticky err; async reset clears all
      @(posedge clk); #1 err_inj = 1'b1;
      @(posedge clk); #1 err_inj = 1'b0;
      @(negedge clk);
      chk("t6_err_set", 192'(err), 192'(1));
      repeat (3) @(negedge clk);
      chk("t6_err_sticky", 192'(err), 192'(1));
      @(posedge clk); #1 req_vld = 4'b0001;
      @(posedge clk); #1 req_vld = 4'b1111;
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_idle",         192'(idle),         192'(1));
      chk("t6_rst_inflight",     192'(inflight),     192'(0));
      chk("t6_rst_err",          192'(err),          192'(0));
      chk("t6_rst_req_rdy",      192'(req_rdy),      192'(0));
      chk("t6_rst_core_in_vld",  192'(core_in_vld),  192'(0));
      chk("t6_rst_core_in_dat",  192'(core_in_dat),  192'(0));
      chk("t6_rst_core_out_rdy", 192'(core_out_rdy), 192'(0));
      chk("t6_rst_rsp_vld",      192'(rsp_vld),      192'(0));
      @(posedge clk); #1 req_vld = '0;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 req_vld = 4'b0010;
      @(posedge clk); #1 req_vld = 4'b0000;
      @(negedge clk);
      chk("t6_post_inflight", 192'(inflight), 192'(1));
      for (int i = 0; i < 20 && !idle; i++) @(negedge clk);
      chk("t6_post_idle", 192'(idle), 192'(1));
      chk("t6_post_err",  192'(err),  192'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/nn_core_arbiter.md
Name: nn_core_arbiter

Overview:
- Shares one HLS-generated inference core (valid/ready streams `input_1_rsc_*` / `layer5_out_rsc_*`) among N_REQ requesters.
- Round-robin arbitration on the input side.
- The core returns results in order, so each accepted request's requester index (tag) is pushed into an in-order tag FIFO; each core output is routed back to the requester at the FIFO head.
- Includes a drain mode for clean quiescing before a core reset or reconfiguration.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IN_W, 180, core input word width (10 features x 18 bit).
- OUT_W, 18, core output word width.
- DEPTH, 4, max in-flight transactions (tag FIFO depth, power of 2).
- TAG_W, $clog2(N_REQ), requester tag width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_dat  in  N_REQ*IN_W  requester input words; requester i occupies slice [i*IN_W +: IN_W].
- req_vld  in  N_REQ  requester valid.
- req_rdy  out  N_REQ  requester ready.
- rsp_dat  out  OUT_W  result word, broadcast to all requesters.
- rsp_vld  out  N_REQ  result valid, one-hot.
- rsp_rdy  in  N_REQ  requester result ready.
- core_in_dat  out  IN_W  to core `input_1_rsc_dat`.
- core_in_vld  out  1  to core `input_1_rsc_vld`.
- core_in_rdy  in  1  from core `input_1_rsc_rdy`.
- core_out_dat  in  OUT_W  from core `layer5_out_rsc_dat`.
- core_out_vld  in  1  from core `layer5_out_rsc_vld`.
- core_out_rdy  out  1  to core `layer5_out_rsc_rdy`.
- drain_req  in  1  level; while high, block new requests and drain in-flight work.
- idle  out  1  1 when no transaction is in flight.
- inflight  out  TAG_W+1... sized $clog2(DEPTH)+1  current in-flight count.
- err  out  1  sticky protocol error.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high; ports named clk and rst.
  - On rst: rr_ptr=0, FIFO empty, inflight=0, state=RUN, err=0.
  - Output values while in reset: idle=1, all rdy/vld outputs 0, core_in_dat=0.
- FSM states: RUN and DRAIN.
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> RUN when drain_req=0 AND inflight=0.
  - In DRAIN, accept is disabled; the output path keeps operating.
- Grant (combinational):
  - g = first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - can_acc = (state==RUN) & !fifo_full.
  - core_in_vld = can_acc & |req_vld.
  - core_in_dat = req_dat slice g, or 0 when no requester is valid.
  - req_rdy[g] = can_acc & core_in_rdy; every other req_rdy bit is 0.
  - core_in_vld never depends on core_in_rdy.
- Accept (when core_in_vld & core_in_rdy):
  - push g into the FIFO;
  - rr_ptr <= (g+1) mod N_REQ, with wrap at N_REQ-1 -> 0.
  - rr_ptr is unchanged on cycles without an accept.
- Return path:
  - h = FIFO head tag.
  - rsp_vld[h] = core_out_vld & !fifo_empty; all other rsp_vld bits are 0.
  - rsp_dat = core_out_dat.
  - core_out_rdy = !fifo_empty & rsp_rdy[h].
  - Pop the FIFO on core_out_vld & core_out_rdy.
- Latency: zero-cycle combinational pass-through in both directions; no data registers.
- Full FIFO: no accept, even if a pop happens in the same cycle (decided, avoids a rdy->rdy combinational path).
- Simultaneous push and pop (FIFO not full): inflight unchanged; both operations take effect.
- Empty FIFO with core_out_vld=1: core_out_rdy=0, no routing, and err is set (sticky until rst).
- A requester holding rsp_rdy=0 back-pressures the core; later results queue inside the core (head-of-line blocking is acceptable).
- idle = fifo_empty. inflight is the exact occupancy, 0..DEPTH.
- drain_req asserted in the same cycle as a pending grant: that request is not accepted.

Optional Feature:
- Macro NN_CORE_ARBITER_PERF_EN.
- When defined: adds output perf_acc_cnt[31:0] and perf_cmp_cnt[31:0].
  - perf_acc_cnt counts accepts; perf_cmp_cnt counts completions.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: the ports do not exist and no counter logic is built.

Decomposition:
- Package nn_arb_pkg:
  - default widths IN_W_DEF=180, OUT_W_DEF=18;
  - state enum {ST_RUN, ST_DRAIN};
  - function rr_pick(vld, ptr), which returns the next grant index.
- Sub-module nn_arb_tag_fifo:
  - parameters DEPTH, TAG_W;
  - ports push, pop, din, dout, full, empty, count;
  - asynchronous active-high reset; no fall-through.

Test Plan:
- Single requester: req_vld=4'b0001, data=known vector, core stub returns 18'h0000F after 3 cycles -> rsp_vld=4'b0001, rsp_dat=18'h0000F; inflight goes 1 then 0; idle=1 after completion.
- Fairness: all 4 requesters assert req_vld continuously, core always ready -> grant order 0,1,2,3,0,1,...; responses routed in the same order; each requester completes 25 of 100 transactions.
- Full FIFO: core_out_vld held 0, all requesters valid -> exactly 4 accepts; after that req_rdy=0 and inflight=4; one pop -> next accept on the following cycle, not the same cycle.
- Back-pressure: head tag=2 and rsp_rdy[2]=0 for 5 cycles -> core_out_rdy=0 for those 5 cycles; no rsp_vld on any other bit; result delivered once rsp_rdy[2]=1.
- Drain: raise drain_req with 3 in flight -> no new accepts; idle=1 after 3 pops; drop drain_req -> accepts resume next cycle.
- Error and reset: core_out_vld=1 with FIFO empty -> err=1 and stays 1; assert rst mid-transaction -> all outputs at reset values immediately (asynchronous), err=0.
